// File: rtl/intr_seq.sv
// intr_seq: nesting interrupt sequencer with priority, vectors and a return stack.
// Optional edge-triggered request capture when INTR_SEQ_EDGE_EN is defined.
module intr_seq #(
  parameter int ADDR_W = 8,
  parameter int N_SRC = 4,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] VEC_BASE = ADDR_W'(8'hF0),
  parameter int VEC_STRIDE = 1,
  localparam int DW = $clog2(DEPTH + 1),
  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_SRC-1:0]  irq,
  input  logic [N_SRC-1:0]  irq_en,
  input  logic              gie,
  input  logic              instr_done,
  input  logic [ADDR_W-1:0] next_pc,
  input  logic              flag_in,
  input  logic              reti,
  output logic              int_take,
  output logic              ret_take,
  output logic [ADDR_W-1:0] int_pc,
  output logic              flag_out,
  output logic [N_SRC-1:0]  irq_ack,
  output logic [N_SRC-1:0]  active,
  output logic [DW-1:0]     depth,
  output logic              err
);

  typedef enum logic [1:0] {
    RUN,
    ENTER,
    LEAVE
  } state_e;

  state_e            state_q, state_d;
  logic              int_take_q, int_take_d;
  logic              ret_take_q, ret_take_d;
  logic [ADDR_W-1:0] int_pc_q, int_pc_d;
  logic              flag_out_q, flag_out_d;
  logic [N_SRC-1:0]  irq_ack_q, irq_ack_d;
  logic [N_SRC-1:0]  active_q, active_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic              err_q, err_d;
  logic [ADDR_W:0]   stk_q [DEPTH];
  logic [ADDR_W:0]   stk_d [DEPTH];

  logic [N_SRC-1:0]  pending;
  logic [N_SRC-1:0]  req;
  logic [SW-1:0]     sel;
  logic [SW-1:0]     act_lo;
  logic              req_any;
  logic              act_any;
  logic              take_ok;

`ifdef INTR_SEQ_EDGE_EN
  logic [N_SRC-1:0]  irq_prev_q, irq_prev_d;
  logic [N_SRC-1:0]  pend_q, pend_d;

  // Latch rising edges; an edge coinciding with the ack re-arms the source.
  always_comb begin
    irq_prev_d = irq;
    pend_d = (pend_q & ~irq_ack_q) | (irq & ~irq_prev_q);
  end

  // Edge detector and pending registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      irq_prev_q <= '0;
      pend_q <= '0;
    end else begin
      irq_prev_q <= irq_prev_d;
      pend_q <= pend_d;
    end
  end

  assign pending = pend_q;
`else
  assign pending = irq;
`endif

  assign req = pending & irq_en & {N_SRC{gie}};

  // Highest-priority request and highest-priority in-service source.
  always_comb begin
    sel = '0;
    act_lo = '0;
    req_any = 1'b0;
    act_any = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        sel = SW'(i);
        req_any = 1'b1;
      end
      if (active_q[i]) begin
        act_lo = SW'(i);
        act_any = 1'b1;
      end
    end
  end

  assign take_ok = req_any && (depth_q < DW'(DEPTH)) &&
                   (!act_any || (sel < act_lo));

  // Next-state: return has precedence over entry at an instruction boundary.
  always_comb begin
    state_d = RUN;
    int_take_d = 1'b0;
    ret_take_d = 1'b0;
    irq_ack_d = '0;
    int_pc_d = int_pc_q;
    flag_out_d = flag_out_q;
    active_d = active_q;
    depth_d = depth_q;
    err_d = err_q;
    stk_d = stk_q;
    if (state_q == RUN && instr_done) begin
      if (reti) begin
        if (depth_q != '0) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (DW'(i) == depth_q - DW'(1)) begin
              int_pc_d = stk_q[i][ADDR_W:1];
              flag_out_d = stk_q[i][0];
            end
          end
          ret_take_d = 1'b1;
          active_d = active_q & (active_q - N_SRC'(1));
          depth_d = depth_q - DW'(1);
          state_d = LEAVE;
        end else begin
          err_d = 1'b1;
        end
      end else if (take_ok) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (DW'(i) == depth_q) begin
            stk_d[i] = {next_pc, flag_in};
          end
        end
        for (int i = 0; i < N_SRC; i++) begin
          if (SW'(i) == sel) begin
            irq_ack_d[i] = 1'b1;
            active_d[i] = 1'b1;
          end
        end
        int_pc_d = VEC_BASE + ADDR_W'(32'(sel) * VEC_STRIDE);
        int_take_d = 1'b1;
        depth_d = depth_q + DW'(1);
        state_d = ENTER;
      end
    end
  end

  // State, stack and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      int_take_q <= 1'b0;
      ret_take_q <= 1'b0;
      int_pc_q <= '0;
      flag_out_q <= 1'b0;
      irq_ack_q <= '0;
      active_q <= '0;
      depth_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stk_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      int_take_q <= int_take_d;
      ret_take_q <= ret_take_d;
      int_pc_q <= int_pc_d;
      flag_out_q <= flag_out_d;
      irq_ack_q <= irq_ack_d;
      active_q <= active_d;
      depth_q <= depth_d;
      err_q <= err_d;
      stk_q <= stk_d;
    end
  end

  assign int_take = int_take_q;
  assign ret_take = ret_take_q;
  assign int_pc = int_pc_q;
  assign flag_out = flag_out_q;
  assign irq_ack = irq_ack_q;
  assign active = active_q;
  assign depth = depth_q;
  assign err = err_q;

endmodule

// File: tb/tb_intr_seq.sv
// tb_intr_seq: scoreboard bench for intr_seq (N_SRC=4, DEPTH=2, base E0, stride 4).
// Edge-mode scenario runs when INTR_SEQ_EDGE_EN is defined.
module tb_intr_seq;

  logic       clock;
  logic       reset;
  logic [3:0] irq;
  logic [3:0] irq_en;
  logic       gie;
  logic       instr_done;
  logic [7:0] next_pc;
  logic       flag_in;
  logic       reti;
  logic       int_take;
  logic       ret_take;
  logic [7:0] int_pc;
  logic       flag_out;
  logic [3:0] irq_ack;
  logic [3:0] active;
  logic [1:0] depth;
  logic       err;

  int checks;
  int failures;

  typedef struct {
    logic       tk;
    logic       rt;
    logic [7:0] pc;
    logic       fl;
    logic [3:0] ack;
    logic [3:0] act;
    logic [1:0] dep;
    logic       er;
  } exp_t;

  exp_t sb[$];

  intr_seq #(
    .ADDR_W(8),
    .N_SRC(4),
    .DEPTH(2),
    .VEC_BASE(8'hE0),
    .VEC_STRIDE(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .irq(irq),
    .irq_en(irq_en),
    .gie(gie),
    .instr_done(instr_done),
    .next_pc(next_pc),
    .flag_in(flag_in),
    .reti(reti),
    .int_take(int_take),
    .ret_take(ret_take),
    .int_pc(int_pc),
    .flag_out(flag_out),
    .irq_ack(irq_ack),
    .active(active),
    .depth(depth),
    .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic exp_t ex(input logic tk, input logic rt,
                              input logic [7:0] pc, input logic fl,
                              input logic [3:0] ack, input logic [3:0] act,
                              input logic [1:0] dep, input logic er);
    exp_t e;
    e.tk = tk;
    e.rt = rt;
    e.pc = pc;
    e.fl = fl;
    e.ack = ack;
    e.act = act;
    e.dep = dep;
    e.er = er;
    return e;
  endfunction

  // Drive one cycle of stimulus, queue its expected result, then score it.
  task automatic cyc(input string tag, input logic rst, input logic [3:0] i_irq,
                     input logic i_gie, input logic i_done,
                     input logic [7:0] i_pc, input logic i_fl,
                     input logic i_reti, input exp_t e);
    exp_t g;
    @(negedge clock);
    reset = rst;
    irq = i_irq;
    gie = i_gie;
    instr_done = i_done;
    next_pc = i_pc;
    flag_in = i_fl;
    reti = i_reti;
    sb.push_back(e);
    @(posedge clock);
    #1;
    g = sb.pop_front();
    chk({tag, ".take"}, 32'(int_take), 32'(g.tk));
    chk({tag, ".ret"}, 32'(ret_take), 32'(g.rt));
    chk({tag, ".ack"}, 32'(irq_ack), 32'(g.ack));
    chk({tag, ".active"}, 32'(active), 32'(g.act));
    chk({tag, ".depth"}, 32'(depth), 32'(g.dep));
    chk({tag, ".err"}, 32'(err), 32'(g.er));
    if (g.tk || g.rt || rst) begin
      chk({tag, ".pc"}, 32'(int_pc), 32'(g.pc));
    end
    if (g.rt || rst) begin
      chk({tag, ".flag"}, 32'(flag_out), 32'(g.fl));
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    irq = 4'h0;
    irq_en = 4'hF;
    gie = 1'b0;
    instr_done = 1'b0;
    next_pc = 8'h00;
    flag_in = 1'b0;
    reti = 1'b0;

    cyc("rst0", 1, 4'hF, 1, 1, 8'h00, 0, 0, ex(0, 0, 8'h00, 0, 4'h0, 4'h0, 0, 0));
    cyc("rst1", 1, 4'hF, 1, 1, 8'h00, 0, 0, ex(0, 0, 8'h00, 0, 4'h0, 4'h0, 0, 0));

`ifdef INTR_SEQ_EDGE_EN
    cyc("e_arm", 0, 4'b0100, 0, 0, 8'h00, 0, 0, ex(0, 0, 8'h00, 0, 4'h0, 4'h0, 0, 0));
    cyc("e_take", 0, 4'b0100, 1, 1, 8'h20, 1, 0, ex(1, 0, 8'hE8, 0, 4'b0100, 4'b0100, 1, 0));
    cyc("e_idle", 0, 4'b0100, 1, 0, 8'h00, 0, 0, ex(0, 0, 8'h00, 0, 4'h0, 4'b0100, 1, 0));
    cyc("e_ret", 0, 4'b0100, 1, 1, 8'h00, 0, 1, ex(0, 1, 8'h20, 1, 4'h0, 4'h0, 0, 0));
    cyc("e_idle2", 0, 4'b0100, 1, 0, 8'h00, 0, 0, ex(0, 0, 8'h00, 0, 4'h0, 4'h0, 0, 0));
    cyc("e_held", 0, 4'b0100, 1, 1, 8'h00, 0, 0, ex(0, 0, 8'h00, 0, 4'h0, 4'h0, 0, 0));
    cyc("e_held2", 0, 4'b0100, 1, 0, 8'h00, 0, 0, ex(0, 0, 8'h00, 0, 4'h0, 4'h0, 0, 0));
`else
    cyc("gie_off", 0, 4'b0001, 0, 1, 8'h10, 0, 0, ex(0, 0, 8'h00, 0, 4'h0, 4'h0, 0, 0));
    cyc("take1", 0, 4'b0010, 1, 1, 8'h15, 1, 0, ex(1, 0, 8'hE4, 0, 4'b0010, 4'b0010, 1, 0));
    cyc("enter1", 0, 4'b0000, 1, 0, 8'h00, 0, 0, ex(0, 0, 8'h00, 0, 4'h0, 4'b0010, 1, 0));
    cyc("lowpri", 0, 4'b1000, 1, 1, 8'h20, 0, 0, ex(0, 0, 8'h00, 0, 4'h0, 4'b0010, 1, 0));
    cyc("eqpri", 0, 4'b0010, 1, 1, 8'h21, 0, 0, ex(0, 0, 8'h00, 0, 4'h0, 4'b0010, 1, 0));
    cyc("take0", 0, 4'b0001, 1, 1, 8'h31, 0, 0, ex(1, 0, 8'hE0, 0, 4'b0001, 4'b0011, 2, 0));
    cyc("enter0", 0, 4'b0001, 1, 0, 8'h00, 0, 0, ex(0, 0, 8'h00, 0, 4'h0, 4'b0011, 2, 0));
    cyc("full", 0, 4'b0001, 1, 1, 8'h40, 0, 0, ex(0, 0, 8'h00, 0, 4'h0, 4'b0011, 2, 0));
    cyc("ret1", 0, 4'b0000, 1, 1, 8'h00, 0, 1, ex(0, 1, 8'h31, 0, 4'h0, 4'b0010, 1, 0));
    cyc("leave1", 0, 4'b0000, 1, 0, 8'h00, 0, 0, ex(0, 0, 8'h00, 0, 4'h0, 4'b0010, 1, 0));
    cyc("ret2", 0, 4'b0000, 1, 1, 8'h00, 0, 1, ex(0, 1, 8'h15, 1, 4'h0, 4'h0, 0, 0));
    cyc("leave2", 0, 4'b0000, 1, 0, 8'h00, 0, 0, ex(0, 0, 8'h00, 0, 4'h0, 4'h0, 0, 0));
    cyc("take2", 0, 4'b0100, 1, 1, 8'h40, 0, 0, ex(1, 0, 8'hE8, 0, 4'b0100, 4'b0100, 1, 0));
    cyc("enter2", 0, 4'b0000, 1, 0, 8'h00, 0, 0, ex(0, 0, 8'h00, 0, 4'h0, 4'b0100, 1, 0));
    cyc("coll", 0, 4'b0001, 1, 1, 8'h77, 1, 1, ex(0, 1, 8'h40, 0, 4'h0, 4'h0, 0, 0));
    cyc("coll_lv", 0, 4'b0001, 1, 0, 8'h00, 0, 0, ex(0, 0, 8'h00, 0, 4'h0, 4'h0, 0, 0));
    cyc("coll_tk", 0, 4'b0001, 1, 1, 8'h52, 1, 0, ex(1, 0, 8'hE0, 0, 4'b0001, 4'b0001, 1, 0));
    cyc("enter3", 0, 4'b0000, 1, 0, 8'h00, 0, 0, ex(0, 0, 8'h00, 0, 4'h0, 4'b0001, 1, 0));
    cyc("ret3", 0, 4'b0000, 1, 1, 8'h00, 0, 1, ex(0, 1, 8'h52, 1, 4'h0, 4'h0, 0, 0));
    cyc("leave3", 0, 4'b0000, 1, 0, 8'h00, 0, 0, ex(0, 0, 8'h00, 0, 4'h0, 4'h0, 0, 0));
    cyc("top", 0, 4'b1000, 1, 1, 8'h60, 0, 0, ex(1, 0, 8'hEC, 0, 4'b1000, 4'b1000, 1, 0));
    cyc("enter4", 0, 4'b0000, 1, 0, 8'h00, 0, 0, ex(0, 0, 8'h00, 0, 4'h0, 4'b1000, 1, 0));
    cyc("ret4", 0, 4'b0000, 1, 1, 8'h00, 0, 1, ex(0, 1, 8'h60, 0, 4'h0, 4'h0, 0, 0));
    cyc("leave4", 0, 4'b0000, 1, 0, 8'h00, 0, 0, ex(0, 0, 8'h00, 0, 4'h0, 4'h0, 0, 0));
    cyc("err", 0, 4'b0000, 1, 1, 8'h00, 0, 1, ex(0, 0, 8'h00, 0, 4'h0, 4'h0, 0, 1));
    cyc("err_h1", 0, 4'b0000, 1, 0, 8'h00, 0, 0, ex(0, 0, 8'h00, 0, 4'h0, 4'h0, 0, 1));
    cyc("err_h2", 0, 4'b0000, 1, 1, 8'h00, 0, 0, ex(0, 0, 8'h00, 0, 4'h0, 4'h0, 0, 1));
    cyc("err_tk", 0, 4'b0010, 1, 1, 8'h81, 1, 0, ex(1, 0, 8'hE4, 0, 4'b0010, 4'b0010, 1, 1));
    cyc("err_en", 0, 4'b0000, 1, 0, 8'h00, 0, 0, ex(0, 0, 8'h00, 0, 4'h0, 4'b0010, 1, 1));
    cyc("rst_mid", 1, 4'b0000, 1, 0, 8'h00, 0, 0, ex(0, 0, 8'h00, 0, 4'h0, 4'h0, 0, 0));
    cyc("post_rst", 0, 4'b0000, 1, 1, 8'h00, 0, 1, ex(0, 0, 8'h00, 0, 4'h0, 4'h0, 0, 1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
